// File: rtl/i2c_mem_slave.sv
// rtl/i2c_mem_slave.sv - oversampled single-byte I2C target memory; optional `I2C_SLV_RANGE_CHECK_EN` NACKs addresses >= DEPTH
module i2c_mem_slave #(
  parameter int DEPTH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_DATA   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_DATA   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [6:0] r_addr;
  logic       r_rw;
  logic       r_nack;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_done;
  logic       r_wr_en;
  logic       r_wr_pend;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_mem [DEPTH];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_bad;
  logic [7:0] w_rd_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_rd_byte  = r_mem[r_addr[AW-1:0]];

`ifdef I2C_SLV_RANGE_CHECK_EN
  assign w_addr_bad = ({1'b0, r_shift[7:1]} >= 8'(DEPTH));
`else
  assign w_addr_bad = 1'b0;
`endif

  assign sda     = r_sda_oe ? 1'b0 : 1'bz;
  assign busy    = r_busy;
  assign done    = r_done;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // Synchronizers reset to the idle-bus level so reset release cannot fake a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl;      r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda;      r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_shift   <= 8'd0;
      r_addr    <= 7'd0;
      r_rw      <= 1'b0;
      r_nack    <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wr_addr <= 7'd0;
      r_wr_data <= 8'd0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
    end else begin
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_pend <= 1'b0;
      if (r_wr_pend) begin
        r_mem[r_addr[AW-1:0]] <= r_shift;
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= r_shift;
      end
      if (w_stop) begin
        r_done   <= (r_state == S_WAIT_STOP);
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_cnt    <= 4'd0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise && r_cnt != 4'd8) begin
              r_shift <= {r_shift[6:0], r_sda_s2};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_addr   <= r_shift[7:1];
              r_rw     <= r_shift[0];
              r_nack   <= w_addr_bad;
              r_sda_oe <= ~w_addr_bad;
              r_state  <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_nack) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_WAIT_STOP;
              end else if (!r_rw) begin
                r_sda_oe <= 1'b0;
                r_cnt    <= 4'd0;
                r_state  <= S_WR_DATA;
              end else begin
                r_sda_oe <= ~w_rd_byte[7];
                r_shift  <= {w_rd_byte[6:0], 1'b0};
                r_cnt    <= 4'd1;
                r_state  <= S_RD_DATA;
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise && r_cnt != 4'd8) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_cnt     <= r_cnt + 4'd1;
              r_wr_pend <= (r_cnt == 4'd7);
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_sda_oe <= 1'b1;
              r_state  <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_WAIT_STOP;
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RD_ACK;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_cnt    <= r_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) r_state <= S_WAIT_STOP;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
